// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the scanned 7-segment display receiver:
// glyph table, FSM encoding, default settle time and digit-to-nibble mapping.
package seg_scan_capture_pkg;

    localparam int SETTLE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Active-high abcdefg patterns; entry k is the glyph that displays hex value k.
    localparam logic [15:0][6:0] GLYPH_TAB = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    // Digit i (en_out[i]) lands in bits [4i+3:4i] of {NumberA, NumberB}.
    function automatic logic [4:0] nibble_lsb(input logic [2:0] digit);
        return {digit, 2'b00};
    endfunction

endpackage

// File: rtl/seg_scan_capture_seg7_glyph_decode.sv
// Purely combinational: active-low segment pattern in, hex nibble plus a
// valid flag out; unrecognised patterns report glyph_vld = 0.
module seg7_glyph_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       glyph_vld
);

    logic [6:0] seg;

    always_comb begin
        seg       = ~seg_n;
        nibble    = 4'd0;
        glyph_vld = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (seg == GLYPH_TAB[k]) begin
                nibble    = 4'(k);
                glyph_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receiver for an 8-digit multiplexed 7-segment bus: each digit must hold
// SETTLE_CYCLES identical samples before capture; a full frame updates NumberA/B.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [6:0]  out7,
    input  logic [7:0]  en_out,
    output logic [15:0] NumberA,
    output logic [15:0] NumberB,
    output logic        Valid,
    output logic        Error,
    output logic [7:0]  DigitMask
);

    localparam logic [7:0] CNT_MAX = 8'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [14:0] sample_q, sample_d;
    logic [14:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [15:0] num_a_q, num_a_d;
    logic [15:0] num_b_q, num_b_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic [7:0]  mask_q, mask_d;

    logic [3:0]  glyph_nib;
    logic        glyph_vld;
    logic        one_hot;
    logic        changed;
    logic [2:0]  dig_idx;
    logic        settling;
    logic [7:0]  cnt_try;
    logic [7:0]  mask_new;

    seg7_glyph_decode u_decode (
        .seg_n     (sample_q[6:0]),
        .nibble    (glyph_nib),
        .glyph_vld (glyph_vld)
    );

    always_comb begin
        one_hot = $onehot(~sample_q[14:7]);
        changed = (sample_q != prev_q);
        dig_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!sample_q[7+i]) begin
                dig_idx = 3'(i);
            end
        end
    end

    always_comb begin
        sample_d = {en_out, out7};
        prev_d   = sample_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        num_a_d  = num_a_q;
        num_b_d  = num_b_q;
        valid_d  = 1'b0;
        error_d  = error_q;
        mask_d   = mask_q;
        settling = 1'b0;
        cnt_try  = 8'd1;
        mask_new = mask_q | (8'd1 << dig_idx);

        unique case (state_q)
            ST_IDLE: begin
                settling = one_hot;
            end
            ST_SETTLE: begin
                if (!changed) begin
                    settling = 1'b1;
                    cnt_try  = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
                end else if (one_hot) begin
                    settling = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    if (one_hot) begin
                        settling = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Entering from IDLE or HOLD also counts as the first stable cycle,
        // so a one-cycle settle time accepts immediately.
        if (settling) begin
            cnt_d   = cnt_try;
            state_d = ST_SETTLE;
            if (cnt_try == CNT_MAX) begin
                state_d = ST_HOLD;
                if (glyph_vld) begin
                    shadow_d[nibble_lsb(dig_idx) +: 4] = glyph_nib;
                    if (mask_new == 8'hFF) begin
                        num_a_d = shadow_d[31:16];
                        num_b_d = shadow_d[15:0];
                        valid_d = 1'b1;
                        mask_d  = 8'h00;
                        error_d = 1'b0;
                    end else begin
                        mask_d = mask_new;
                    end
                end else begin
                    error_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            sample_q <= '1;
            prev_q   <= '1;
            cnt_q    <= 8'd0;
            shadow_q <= 32'd0;
            num_a_q  <= 16'd0;
            num_b_q  <= 16'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            mask_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            num_a_q  <= num_a_d;
            num_b_q  <= num_b_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            mask_q   <= mask_d;
        end
    end

    assign NumberA   = num_a_q;
    assign NumberB   = num_b_q;
    assign Valid     = valid_q;
    assign Error     = error_q;
    assign DigitMask = mask_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Drives display segments (directed scenarios then random) and scores frame
// captures against a segment-level model of hold lengths.
module tb_seg_scan_capture;

    localparam int S = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [6:0]  out7;
    logic [7:0]  en_out;
    logic [15:0] NumberA;
    logic [15:0] NumberB;
    logic        Valid;
    logic        Error;
    logic [7:0]  DigitMask;

    always #5 Clk = ~Clk;

    seg_scan_capture #(.SETTLE_CYCLES(S)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .out7      (out7),
        .en_out    (en_out),
        .NumberA   (NumberA),
        .NumberB   (NumberB),
        .Valid     (Valid),
        .Error     (Error),
        .DigitMask (DigitMask)
    );

    int checks = 0;
    int failures = 0;

    // Active-high abcdefg glyphs for hex 0..F.
    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic [3:0]  m_dig [8];
    logic [7:0]  m_mask;
    logic        m_err;
    logic [31:0] exp_q [$];
    logic [14:0] last_pins;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int digit_of(input logic [7:0] en);
        int zeros = 0;
        int pos = -1;
        for (int i = 0; i < 8; i++) begin
            if (!en[i]) begin
                zeros++;
                pos = i;
            end
        end
        return (zeros == 1) ? pos : -1;
    endfunction

    // A digit shown for n cycles with unchanging pins is taken iff n >= S.
    task automatic model_seg(input logic [7:0] en, input logic [6:0] o7, input int n);
        int d;
        logic [3:0] nib;
        bit ok;
        logic [31:0] v;
        d = digit_of(en);
        ok = 1'b0;
        nib = 4'd0;
        if (d < 0 || n < S) return;
        for (int k = 0; k < 16; k++) begin
            if (~o7 == glyph[k]) begin
                ok = 1'b1;
                nib = 4'(k);
            end
        end
        if (!ok) begin
            m_err = 1'b1;
            return;
        end
        m_dig[d] = nib;
        m_mask[d] = 1'b1;
        if (m_mask == 8'hFF) begin
            for (int i = 0; i < 8; i++) v[4*i +: 4] = m_dig[i];
            exp_q.push_back(v);
            m_mask = 8'h00;
            m_err = 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;
        m_mask = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic show(input logic [7:0] en, input logic [6:0] o7, input int n);
        en_out = en;
        out7 = o7;
        @(posedge Clk); #1;
        chk("digit_mask", {24'd0, DigitMask}, {24'd0, m_mask});
        chk("error_flag", {31'd0, Error}, {31'd0, m_err});
        model_seg(en, o7, n);
        last_pins = {en, o7};
        repeat (n - 1) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic show_frame(input logic [31:0] v, input int n);
        for (int d = 7; d >= 0; d--) begin
            show(~(8'd1 << d), ~glyph[v[4*d +: 4]], n);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        en_out = 8'hFF;
        out7 = 7'h7F;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_clear();
        last_pins = '1;
        chk("rst_number_a", {16'd0, NumberA}, 32'd0);
        chk("rst_number_b", {16'd0, NumberB}, 32'd0);
        chk("rst_valid", {31'd0, Valid}, 32'd0);
        chk("rst_error", {31'd0, Error}, 32'd0);
        chk("rst_digit_mask", {24'd0, DigitMask}, 32'd0);
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge Clk);
            if (Valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL valid_unexpected actual=%0h_%0h required=no_pulse", NumberA, NumberB);
                end else begin
                    e = exp_q.pop_front();
                    chk("number_ab", {NumberA, NumberB}, e);
                    chk("error_on_valid", {31'd0, Error}, 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] en;
        logic [6:0] o7;
        int n;
        do_reset();

        show_frame(32'h1234ABCD, 6);
        show(8'hFF, 7'h7F, 3);

        show(8'b11111110, 7'b0000001, 3);
        show(8'hFF, 7'h7F, 2);

        show(8'b11111110, 7'b1111111, 8);
        show(8'hFF, 7'h7F, 2);
        show_frame(32'h0F1E2D3C, 5);

        for (int i = 0; i < 10; i++) show(8'b11111100, 7'($urandom), 1);

        for (int d = 7; d >= 3; d--) show(~(8'd1 << d), ~glyph[d], 6);
        do_reset();
        show_frame(32'hFFFF0000, 6);

        show_frame(32'h89674523, 6);
        show(8'b11110111, ~glyph[5], 6);
        show(8'b11110111, ~glyph[9], 1);
        show(8'b11110111, ~glyph[5], 6);
        show(8'b11111011, ~glyph[2], 1);
        show(8'b11111011, ~glyph[7], 5);
        show(8'b11111101, ~glyph[1], 4);
        show(8'b11111110, ~glyph[0], 4);

        for (int s = 0; s < 300; s++) begin
            do begin
                if ($urandom_range(0, 9) < 8) en = ~(8'd1 << $urandom_range(0, 7));
                else en = 8'($urandom);
                if ($urandom_range(0, 9) < 8) o7 = ~glyph[$urandom_range(0, 15)];
                else o7 = 7'($urandom);
            end while ({en, o7} == last_pins);
            n = $urandom_range(1, 8);
            show(en, o7, n);
        end

        show(8'hFF, 7'h7F, 4);
        repeat (3) @(posedge Clk);
        #1;
        chk("pending_frames", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
